music_key_sequencer: RTL and testbench

- Records the 6-bit active-low music key vector as run-length events while the box is in the record state.
- Replays the events as an active-low key vector in the play state.
- output_MusicKey drives the key input of the music keys controller, so recorded performances sound the same as live play.
- Sits beside the state controller; runs entirely in the 1 kHz domain, so one tick is 1 ms.

---
 rtl/music_key_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_music_key_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/music_key_sequencer.sv
`timescale 1ns/1ps
// Run-length recorder/replayer for the active-low music key vector.
// Records {vec, hold} events while in REC_STATE and replays them cycle-exact in PLAY_STATE.
module music_key_sequencer #(
    parameter int         DEPTH      = 64,
    parameter int         ADDR_W     = 6,
    parameter int         HOLD_W     = 10,
    parameter logic [4:0] REC_STATE  = 5'd4,
    parameter logic [4:0] PLAY_STATE = 5'd5
) (
    input  logic              CLK_1Khz,
    input  logic              reset_n,
    input  logic [4:0]        currentState,
    input  logic [5:0]        input_MusicKey,
    output logic [5:0]        output_MusicKey,
    output logic              recording,
    output logic              playing,
    output logic              rec_full,
    output logic              play_done,
    output logic [ADDR_W:0]   entry_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REC  = 3'd1;
    localparam logic [2:0] S_FULL = 3'd2;
    localparam logic [2:0] S_PLAY = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [HOLD_W-1:0] HOLD_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [5:0]        KEYS_IDLE  = 6'b111111;

    // Event storage is intentionally not reset; entry_count alone marks valid entries.
    logic [5+HOLD_W:0] mem_q [DEPTH];

    logic [2:0]        state_q, state_d;
    logic [5:0]        cur_vec_q, cur_vec_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [HOLD_W-1:0] remain_q, remain_d;
    logic [5:0]        out_q, out_d;
    logic              play_done_q, play_done_d;
    logic              recording_q, playing_q, rec_full_q;

    logic              wr_en;
    logic [5+HOLD_W:0] wr_data;
    logic [ADDR_W:0]   rd_next;
    logic [5+HOLD_W:0] head_entry;
    logic [5+HOLD_W:0] next_entry;

    assign rd_next    = {1'b0, rd_idx_q} + COUNT_ONE;
    assign head_entry = mem_q[0];
    assign next_entry = mem_q[rd_next[ADDR_W-1:0]];

    always_comb begin
        state_d     = state_q;
        cur_vec_d   = cur_vec_q;
        hold_d      = hold_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        remain_d    = remain_q;
        out_d       = out_q;
        play_done_d = 1'b0;
        wr_en       = 1'b0;
        wr_data     = {cur_vec_q, hold_q};

        case (state_q)
            S_IDLE: begin
                out_d = KEYS_IDLE;
                if (currentState == REC_STATE) begin
                    cur_vec_d = input_MusicKey;
                    hold_d    = HOLD_ONE;
                    count_d   = '0;
                    state_d   = S_REC;
                end else if (currentState == PLAY_STATE) begin
                    if (count_q != '0) begin
                        rd_idx_d = '0;
                        out_d    = head_entry[5+HOLD_W:HOLD_W];
                        remain_d = head_entry[HOLD_W-1:0];
                        state_d  = S_PLAY;
                    end else begin
                        play_done_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end

            // Leaving record flushes the open run; a saturated hold closes the run early.
            S_REC: begin
                if (currentState != REC_STATE) begin
                    wr_en   = 1'b1;
                    count_d = count_q + COUNT_ONE;
                    state_d = S_IDLE;
                end else if ((input_MusicKey != cur_vec_q) || (hold_q == HOLD_MAX)) begin
                    wr_en     = 1'b1;
                    count_d   = count_q + COUNT_ONE;
                    cur_vec_d = input_MusicKey;
                    hold_d    = HOLD_ONE;
                    if (count_q + COUNT_ONE == COUNT_FULL) begin
                        state_d = S_FULL;
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            S_FULL: begin
                if (currentState != REC_STATE) begin
                    state_d = S_IDLE;
                end
            end

            S_PLAY: begin
                if (currentState != PLAY_STATE) begin
                    out_d   = KEYS_IDLE;
                    state_d = S_IDLE;
                end else if (remain_q > HOLD_ONE) begin
                    remain_d = remain_q - HOLD_ONE;
                end else if (rd_next < count_q) begin
                    rd_idx_d = rd_next[ADDR_W-1:0];
                    out_d    = next_entry[5+HOLD_W:HOLD_W];
                    remain_d = next_entry[HOLD_W-1:0];
                end else begin
                    out_d       = KEYS_IDLE;
                    play_done_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                out_d = KEYS_IDLE;
                if (currentState != PLAY_STATE) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                out_d   = KEYS_IDLE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_1Khz) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_vec_q   <= KEYS_IDLE;
            hold_q      <= '0;
            count_q     <= '0;
            rd_idx_q    <= '0;
            remain_q    <= '0;
            out_q       <= KEYS_IDLE;
            play_done_q <= 1'b0;
            recording_q <= 1'b0;
            playing_q   <= 1'b0;
            rec_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_vec_q   <= cur_vec_d;
            hold_q      <= hold_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            remain_q    <= remain_d;
            out_q       <= out_d;
            play_done_q <= play_done_d;
            recording_q <= (state_d == S_REC);
            playing_q   <= (state_d == S_PLAY);
            rec_full_q  <= (state_d == S_FULL);
        end
    end

    always_ff @(posedge CLK_1Khz) begin
        if (reset_n && wr_en) begin
            mem_q[count_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign output_MusicKey = out_q;
    assign recording       = recording_q;
    assign playing         = playing_q;
    assign rec_full        = rec_full_q;
    assign play_done       = play_done_q;
    assign entry_count     = count_q;

endmodule

// File: tb/tb_music_key_sequencer.sv
`timescale 1ns/1ps
// Randomized self-checking bench for music_key_sequencer: recorded key samples are
// run-length encoded by a queue model, and replay is checked against the expanded stream.
module tb_music_key_sequencer;

    localparam int         DEPTH      = 64;
    localparam int         HOLD_MAX   = 1023;
    localparam logic [4:0] REC_STATE  = 5'd4;
    localparam logic [4:0] PLAY_STATE = 5'd5;
    localparam logic [4:0] OTHER      = 5'd0;

    logic       CLK_1Khz = 1'b0;
    logic       reset_n;
    logic [4:0] currentState;
    logic [5:0] input_MusicKey;
    logic [5:0] output_MusicKey;
    logic       recording, playing, rec_full, play_done;
    logic [6:0] entry_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] plan[$];
    logic [5:0] rec_samples[$];
    logic [5:0] m_vec[$];
    int         m_hold[$];

    music_key_sequencer dut (
        .CLK_1Khz        (CLK_1Khz),
        .reset_n         (reset_n),
        .currentState    (currentState),
        .input_MusicKey  (input_MusicKey),
        .output_MusicKey (output_MusicKey),
        .recording       (recording),
        .playing         (playing),
        .rec_full        (rec_full),
        .play_done       (play_done),
        .entry_count     (entry_count)
    );

    always #5 CLK_1Khz = ~CLK_1Khz;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] st, input logic [5:0] keys);
        currentState   = st;
        input_MusicKey = keys;
        @(posedge CLK_1Khz);
        #1;
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Run-length encode every sampled vector, runs capped at HOLD_MAX ticks.
    function automatic void build_model();
        m_vec.delete();
        m_hold.delete();
        foreach (rec_samples[i]) begin
            if (m_vec.size() == 0 || rec_samples[i] != m_vec[m_vec.size()-1] ||
                m_hold[m_hold.size()-1] == HOLD_MAX) begin
                m_vec.push_back(rec_samples[i]);
                m_hold.push_back(1);
            end else begin
                m_hold[m_hold.size()-1] = m_hold[m_hold.size()-1] + 1;
            end
        end
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_out"}, output_MusicKey, 6'h3F);
        checkOutput({tag, "_recording"}, recording, 1'b0);
        checkOutput({tag, "_playing"}, playing, 1'b0);
        checkOutput({tag, "_rec_full"}, rec_full, 1'b0);
        checkOutput({tag, "_play_done"}, play_done, 1'b0);
    endtask

    // Drives plan[] while in REC_STATE (device must start idle), then leaves via exit_state.
    task automatic record_phase(input logic [4:0] exit_state);
        int  closed;
        bit  full;
        rec_samples.delete();
        foreach (plan[i]) begin
            rec_samples.push_back(plan[i]);
            applyStimulus(REC_STATE, plan[i]);
            build_model();
            closed = m_vec.size() - 1;
            full   = (closed >= DEPTH);
            checkOutput("rec_count", entry_count, min_int(closed, DEPTH));
            checkOutput("rec_recording", recording, !full);
            checkOutput("rec_full", rec_full, full);
            checkOutput("rec_out", output_MusicKey, 6'h3F);
        end
        applyStimulus(exit_state, 6'h3F);
        while (m_vec.size() > DEPTH) begin
            void'(m_vec.pop_back());
            void'(m_hold.pop_back());
        end
        checkOutput("rec_final_count", entry_count, m_vec.size());
        checkOutput("rec_exit_recording", recording, 1'b0);
        checkOutput("rec_exit_full", rec_full, 1'b0);
    endtask

    // Replays the model; abort_after>0 leaves PLAY_STATE after that many cycles.
    task automatic play_phase(input int abort_after);
        logic [5:0] expv[$];
        foreach (m_vec[i]) begin
            for (int k = 0; k < m_hold[i]; k++) expv.push_back(m_vec[i]);
        end
        for (int j = 1; j <= expv.size(); j++) begin
            if (abort_after > 0 && j > abort_after) begin
                applyStimulus(OTHER, 6'($urandom));
                checkOutput("abort_out", output_MusicKey, 6'h3F);
                checkOutput("abort_play_done", play_done, 1'b0);
                checkOutput("abort_playing", playing, 1'b0);
                return;
            end
            applyStimulus(PLAY_STATE, 6'($urandom));
            checkOutput("play_out", output_MusicKey, expv[j-1]);
            checkOutput("play_playing", playing, 1'b1);
            checkOutput("play_done_early", play_done, 1'b0);
        end
        applyStimulus(PLAY_STATE, 6'($urandom));
        checkOutput("end_out", output_MusicKey, 6'h3F);
        checkOutput("end_play_done", play_done, 1'b1);
        checkOutput("end_playing", playing, 1'b0);
        applyStimulus(PLAY_STATE, 6'($urandom));
        checkOutput("done_out", output_MusicKey, 6'h3F);
        checkOutput("done_pulse_cleared", play_done, 1'b0);
        applyStimulus(OTHER, 6'h3F);
        checkIdle("after_play");
    endtask

    initial begin
        logic [5:0] v;
        int         len;

        reset_n        = 1'b0;
        currentState   = OTHER;
        input_MusicKey = 6'h3F;
        repeat (3) @(posedge CLK_1Khz);
        #1;
        checkIdle("reset");
        checkOutput("reset_count", entry_count, 0);
        reset_n = 1'b1;
        applyStimulus(OTHER, 6'h3F);
        checkIdle("post_reset");

        $display("[TB] basic record and replay");
        plan.delete();
        repeat (10) plan.push_back(6'h3F);
        repeat (5)  plan.push_back(6'h3E);
        repeat (7)  plan.push_back(6'h3F);
        record_phase(OTHER);
        checkOutput("basic_entries", entry_count, 3);
        play_phase(0);

        $display("[TB] long hold split");
        plan.delete();
        repeat (2100) plan.push_back(6'h3B);
        record_phase(OTHER);
        checkOutput("long_entries", entry_count, 3);
        checkOutput("long_last_hold", m_hold[2], 54);
        play_phase(0);

        $display("[TB] buffer overflow");
        plan.delete();
        for (int i = 0; i < 100; i++) plan.push_back((i % 2 == 0) ? 6'h3F : 6'h3D);
        record_phase(OTHER);
        checkOutput("ovf_entries", entry_count, 64);
        play_phase(0);

        $display("[TB] playback abort and restart");
        plan.delete();
        repeat (20) plan.push_back(6'h3E);
        repeat (5)  plan.push_back(6'h3F);
        record_phase(OTHER);
        play_phase(4);
        play_phase(0);

        $display("[TB] reset mid-record and empty playback");
        for (int i = 0; i < 15; i++) applyStimulus(REC_STATE, 6'($urandom));
        reset_n      = 1'b0;
        currentState = OTHER;
        @(posedge CLK_1Khz);
        #1;
        checkIdle("mid_reset");
        checkOutput("mid_reset_count", entry_count, 0);
        reset_n = 1'b1;
        applyStimulus(OTHER, 6'h3F);
        m_vec.delete();
        m_hold.delete();
        play_phase(0);

        $display("[TB] randomized sessions");
        for (int t = 0; t < 8; t++) begin
            plan.delete();
            len = $urandom_range(1, 250);
            v   = 6'($urandom);
            while (plan.size() < len) begin
                if ($urandom_range(0, 3) != 0) v = 6'($urandom);
                repeat ($urandom_range(1, 12)) plan.push_back(v);
            end
            if ($urandom_range(0, 1) == 1) begin
                record_phase(PLAY_STATE);
            end else begin
                record_phase(OTHER);
                applyStimulus(OTHER, 6'($urandom));
            end
            play_phase(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
